ttt2_resp_misr: RTL and testbench

- Downstream response compactor for the ttt2 combinational next-state/output core.
- Consumes the core's 21-bit output vector (g0..m0, z, n0..t0, a0..f0, packed LSB = g0 in port-list order) through a valid/ready handshake.
- Folds each vector into a multiple-input signature register (MISR) and compares the final signature with an expected value after a programmed number of patterns.
- Sits between the benchmark core and the test-status logic of the sequential harness.

---
 rtl/ttt2_harness_pkg.sv | 39 +++
 rtl/ttt2_resp_misr_step.sv | 19 +
 rtl/ttt2_resp_misr.sv | 140 ++++++++++++++
 tb/tb_ttt2_resp_misr.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt2_harness_pkg.sv
// Shared types and constants for the ttt2 sequential harness: response width,
// MISR polynomial, response-vector field positions and the compactor state type.
package ttt2_harness_pkg;

  localparam int RESP_W = 21;

  // x^21 + x^2 + 1; bit 0 is implicit in the MISR recurrence.
  localparam logic [RESP_W-1:0] TTT2_MISR_POLY = 21'h000004;

  // Field positions of the core's output vector, LSB first.
  localparam int G0_IDX = 0;
  localparam int H0_IDX = 1;
  localparam int I0_IDX = 2;
  localparam int J0_IDX = 3;
  localparam int K0_IDX = 4;
  localparam int L0_IDX = 5;
  localparam int M0_IDX = 6;
  localparam int Z_IDX  = 7;
  localparam int N0_IDX = 8;
  localparam int O0_IDX = 9;
  localparam int P0_IDX = 10;
  localparam int Q0_IDX = 11;
  localparam int R0_IDX = 12;
  localparam int S0_IDX = 13;
  localparam int T0_IDX = 14;
  localparam int A0_IDX = 15;
  localparam int B0_IDX = 16;
  localparam int C0_IDX = 17;
  localparam int D0_IDX = 18;
  localparam int E0_IDX = 19;
  localparam int F0_IDX = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ttt2_resp_misr_step.sv
// Combinational MISR next-signature function, shared with the pattern LFSR.
module misr_step #(
  parameter int            W    = 21,
  parameter logic [W-1:0]  POLY = 21'h000004
) (
  input  logic [W-1:0] sig_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] nxt_o
);

  always_comb begin
    nxt_o    = '0;
    nxt_o[0] = sig_i[W-1] ^ data_i[0];
    for (int i = 1; i < W; i++) begin
      nxt_o[i] = sig_i[i-1] ^ data_i[i] ^ (POLY[i] & sig_i[W-1]);
    end
  end

endmodule

// File: rtl/ttt2_resp_misr.sv
// Response compactor for the ttt2 core: folds accepted vectors into a MISR and
// compares with an expected signature. Optional mask input: TTT2_RESP_MISR_MASK_EN.
//
// Handshake: a vector is consumed on a rising edge where in_valid && in_ready;
// in_ready depends only on state, never on in_valid.
module ttt2_resp_misr
  import ttt2_harness_pkg::*;
#(
  parameter int           W     = RESP_W,
  parameter int           CNT_W = 16,
  parameter logic [W-1:0] POLY  = TTT2_MISR_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     seed,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [W-1:0]     exp_sig,
`ifdef TTT2_RESP_MISR_MASK_EN
  input  logic [W-1:0]     mask,
`endif
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [W-1:0]     signature,
  output logic [CNT_W-1:0] count,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [W-1:0]     sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [W-1:0]     exp_q, exp_d;
  logic             pass_q, pass_d;
  logic [W-1:0]     data_eff;
  logic [W-1:0]     sig_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;

  assign beat    = in_valid & in_ready;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef TTT2_RESP_MISR_MASK_EN
  logic [W-1:0] mask_q, mask_d;
  // Gate with beat so unknown data on idle cycles never reaches the MISR.
  assign data_eff = beat ? (in_data & ~mask_q) : '0;
`else
  assign data_eff = beat ? in_data : '0;
`endif

  misr_step #(
    .W    (W),
    .POLY (POLY)
  ) u_step (
    .sig_i  (sig_q),
    .data_i (data_eff),
    .nxt_o  (sig_nxt)
  );

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
`ifdef TTT2_RESP_MISR_MASK_EN
    mask_d  = mask_q;
`endif
    if (abort) begin
      state_d = IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sig_d   = seed;
            cnt_d   = '0;
            num_d   = num_patterns;
            exp_d   = exp_sig;
`ifdef TTT2_RESP_MISR_MASK_EN
            mask_d  = mask;
`endif
            state_d = (num_patterns == '0) ? DONE : RUN;
            pass_d  = (num_patterns == '0) && (seed == exp_sig);
          end
        end
        RUN: begin
          if (beat) begin
            sig_d = sig_nxt;
            cnt_d = cnt_inc;
            if (cnt_inc == num_q) begin
              state_d = DONE;
              pass_d  = (sig_nxt == exp_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
`ifdef TTT2_RESP_MISR_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
`ifdef TTT2_RESP_MISR_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q & done;
  assign signature = sig_q;
  assign count     = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ttt2_resp_misr.sv
// Randomised scoreboard bench for ttt2_resp_misr; reference model treats the
// signature as a polynomial over GF(2) multiplied by x modulo x^21+x^2+1.
module tb_ttt2_resp_misr;

  localparam int           W     = 21;
  localparam int           CNT_W = 16;
  localparam logic [W-1:0] POLY  = 21'h000004;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [W-1:0]     seed;
  logic [CNT_W-1:0] num_patterns;
  logic [W-1:0]     exp_sig;
`ifdef TTT2_RESP_MISR_MASK_EN
  logic [W-1:0]     mask;
`endif
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [W-1:0]     signature;
  logic [CNT_W-1:0] count;
  ttt2_harness_pkg::state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // {pass, count, signature} expected at each DONE entry
  logic [W+CNT_W:0] exp_q[$];
  logic [W-1:0]     stim_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  ttt2_resp_misr dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .seed         (seed),
    .num_patterns (num_patterns),
    .exp_sig      (exp_sig),
`ifdef TTT2_RESP_MISR_MASK_EN
    .mask         (mask),
`endif
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .signature    (signature),
    .count        (count),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_step(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ ({1'b1, {W{1'b0}}} | {1'b0, POLY} | (W+1)'(1));
    return t[W-1:0] ^ d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty queue, required no done");
      end else begin
        logic [W+CNT_W:0] e;
        e = exp_q.pop_front();
        check("final_signature", signature, e[W-1:0]);
        check("final_count", count, e[W+CNT_W-1:W]);
        check("final_pass", pass, e[W+CNT_W]);
      end
    end
    done_prev <= done;
  end

  // ---------------- driver tasks ----------------
  task automatic arm(input logic [W-1:0] seed_v, input int n, input logic [W-1:0] exp_v,
                     input logic [W-1:0] mask_v);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    seed         = seed_v;
    num_patterns = CNT_W'(n);
    exp_sig      = exp_v;
`ifdef TTT2_RESP_MISR_MASK_EN
    mask         = mask_v;
`endif
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // exp_sel: 0 fixed exp value, 1 matching model, 2 model with one bit flipped
  task automatic do_run(input logic [W-1:0] seed_v, input logic [W-1:0] mask_v,
                        input int exp_sel, input logic [W-1:0] exp_fixed);
    logic [W-1:0] m, e;
    int n, idx, guard;
`ifndef TTT2_RESP_MISR_MASK_EN
    mask_v = '0;
`endif
    m = seed_v;
    foreach (stim_q[k]) m = model_step(m, stim_q[k] & ~mask_v);
    if (exp_sel == 0)      e = exp_fixed;
    else if (exp_sel == 1) e = m;
    else                   e = m ^ (W'(1) << $urandom_range(0, W-1));
    n = stim_q.size();
    exp_q.push_back({(m == e), CNT_W'(n), m});
    arm(seed_v, n, e, mask_v);
    idx = 0;
    guard = 0;
    while (idx < n && guard < 2000) begin
      if ($urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_data  = stim_q[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
      end
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got %0d beats, required %0d", idx, n);
    end
    in_valid = 1'b1;
    in_data  = W'($urandom);
    check("ready_low_after_last", in_ready, 1'b0);
    check("done_after_last", done, 1'b1);
    @(negedge clk);
    check("no_extra_beat", count, CNT_W'(n));
    in_valid = 1'b0;
    stim_q.delete();
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [W-1:0] s, v0, v1, m2;
    rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; num_patterns = '0;
    exp_sig = '0; in_valid = 1'b0; in_data = '0;
`ifdef TTT2_RESP_MISR_MASK_EN
    mask = '0;
`endif
    #12;
    check("rst_signature", signature, '0);
    check("rst_count", count, '0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_state", dbg_state, ttt2_harness_pkg::IDLE);
    @(negedge clk);
    rst = 1'b0;

    // single vector, matching and non-matching expectation
    stim_q.push_back(21'h000001);
    do_run('0, '0, 0, 21'h000001);
    check("one_vec_sig", signature, 21'h000001);
    check("one_vec_pass", pass, 1'b1);
    stim_q.push_back(21'h000001);
    do_run('0, '0, 0, 21'h000000);
    check("one_vec_nopass", pass, 1'b0);

    // feedback tap exercised on the second beat
    stim_q.push_back(21'h100000);
    do_run('0, '0, 0, 21'h100000);
    check("two_vec_beat1_sig", signature, 21'h100000);
    stim_q.push_back(21'h100000);
    stim_q.push_back(21'h000000);
    do_run('0, '0, 0, 21'h000005);
    check("two_vec_sig", signature, 21'h000005);
    check("two_vec_pass", pass, 1'b1);

    // zero patterns
    do_run(21'h1ABCDE, '0, 0, 21'h1ABCDE);
    check("zero_num_sig", signature, 21'h1ABCDE);
    do_run(21'h1ABCDE, '0, 0, 21'h0ABCDE);
    check("zero_num_nopass", pass, 1'b0);

    // backpressure with gaps, four vectors
    for (int i = 0; i < 4; i++) stim_q.push_back(W'($urandom));
    do_run(W'($urandom), '0, 1, '0);

    // abort during a beat at count 2; start while running ignored
    s  = W'($urandom);
    v0 = W'($urandom);
    v1 = W'($urandom);
    m2 = model_step(model_step(s, v0), v1);
    arm(s, 5, '0, '0);
    check("run_busy", busy, 1'b1);
    in_valid = 1'b1; in_data = v0;
    @(negedge clk);
    in_data = v1; start = 1'b1; seed = ~s; num_patterns = 16'd1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_run_ignored_sig", signature, m2);
    check("start_in_run_ignored_cnt", count, 16'd2);
    in_data = W'($urandom); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_count", count, 16'd2);
    check("abort_sig", signature, m2);
    check("abort_done", done, 1'b0);
    check("abort_ready", in_ready, 1'b0);
    check("abort_state", dbg_state, ttt2_harness_pkg::IDLE);

    // asynchronous reset in the middle of a run
    arm(W'($urandom), 8, '0, '0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = W'($urandom);
      @(negedge clk);
    end
    check("pre_reset_count", count, 16'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_sig", signature, '0);
    check("mid_rst_count", count, '0);
    check("mid_rst_ready", in_ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_state", dbg_state, ttt2_harness_pkg::IDLE);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_beat", count, '0);
    check("post_rst_ready", in_ready, 1'b0);
    in_valid = 1'b0;

`ifdef TTT2_RESP_MISR_MASK_EN
    // fully masked data: seed evolves with zero input only
    s = W'($urandom);
    v0 = s;
    for (int i = 0; i < 6; i++) begin
      stim_q.push_back(W'($urandom));
      v0 = model_step(v0, '0);
    end
    do_run(s, 21'h1FFFFF, 1, '0);
    check("mask_all_sig", signature, v0);
`endif

    // random runs
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) stim_q.push_back(W'($urandom));
      do_run(W'($urandom), W'($urandom), $urandom_range(1, 2), '0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
